// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision sequencer: segment layout,
// sequencer states, counter width and saturating/degenerate-segment helpers.
package collision_pkg;

    localparam int COORD_W   = 8;
    localparam int LINE_ID_W = 8;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] z1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COORD_W-1:0] z2;
    } seg_t;

    localparam int SEG_W   = $bits(seg_t);
    localparam int ENTRY_W = SEG_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // A segment whose endpoints coincide has zero length.
    function automatic logic is_degenerate(input seg_t s);
        return (s.x1 == s.x2) && (s.y1 == s.y2) && (s.z1 == s.z2);
    endfunction

endpackage

// File: rtl/collision_sequencer_seg_fifo.sv
// Synchronous FIFO holding {last, segment} entries between the G-code parser
// and the issue logic. Show-ahead read: pop_data is the current head entry.
module seg_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_FULL);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/collision_sequencer.sv
// Paces buffered G-code segments into the CollisionDetect engine, forwards hits
// and reports job completion. Option macro: SEQ_DEGENERATE_DROP_EN.
module collision_sequencer
    import collision_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int ISSUE_GAP    = 2,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seg_val,
    output logic                 seg_rdy,
    input  logic                 seg_last,
    input  logic [SEG_W-1:0]     seg_data,
    output logic                 cd_in_val,
    output logic [SEG_W-1:0]     cd_seg,
    input  logic                 cd_out_val,
    input  logic [LINE_ID_W-1:0] cd_line_id,
    output logic                 hit_val,
    output logic [LINE_ID_W-1:0] hit_line_id,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     seg_count,
    output logic [CNT_W-1:0]     hit_count
);

    localparam int GAP_W = $clog2(ISSUE_GAP + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(ISSUE_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_ONE    = DRN_W'(1);

    seq_state_e           state_r;
    seq_state_e           next_state_s;
    logic                 clear_cnt_s;
    logic [GAP_W-1:0]     gap_r;
    logic [DRN_W-1:0]     drain_cnt_r;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_acc_s;
    logic                 fifo_pop_s;
    logic [ENTRY_W-1:0]   pop_entry_s;
    seg_t                 pop_seg_s;
    logic                 pop_last_s;
    logic                 drop_s;
    logic                 issue_s;

    logic                 cd_in_val_r;
    seg_t                 cd_seg_r;
    logic                 hit_val_r;
    logic [LINE_ID_W-1:0] hit_line_id_r;
    logic                 busy_r;
    logic                 done_r;
    logic [CNT_W-1:0]     seg_count_r;
    logic [CNT_W-1:0]     hit_count_r;

    seg_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (seg_val),
        .push_data ({seg_last, seg_data}),
        .pop       (fifo_pop_s),
        .pop_data  (pop_entry_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign seg_rdy    = !fifo_full_s;
    assign push_acc_s = seg_val && !fifo_full_s;
    assign fifo_pop_s = (state_r == RUN) && !fifo_empty_s && (gap_r == '0);
    assign pop_seg_s  = pop_entry_s[SEG_W-1:0];
    assign pop_last_s = pop_entry_s[SEG_W];

`ifdef SEQ_DEGENERATE_DROP_EN
    assign drop_s = is_degenerate(pop_seg_s);
`else
    assign drop_s = 1'b0;
`endif

    // A dropped segment still leaves the FIFO but never reaches the engine.
    assign issue_s = fifo_pop_s && !drop_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a new job starts as soon as anything is queued.
    always_comb begin
        next_state_s = state_r;
        clear_cnt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (push_acc_s || !fifo_empty_s) begin
                    next_state_s = RUN;
                    clear_cnt_s  = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (fifo_pop_s && pop_last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Issue pacing and drain timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_r       <= '0;
            drain_cnt_r <= '0;
        end else begin
            if (issue_s) begin
                gap_r <= GAP_LOAD;
            end else if (gap_r != '0) begin
                gap_r <= gap_r - GAP_ONE;
            end
            if (state_r == DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DRN_ONE;
            end else begin
                drain_cnt_r <= '0;
            end
        end
    end

    // Engine-facing strobe/segment and forwarded hit results.
    always_ff @(posedge clk) begin
        if (reset) begin
            cd_in_val_r   <= 1'b0;
            cd_seg_r      <= '0;
            hit_val_r     <= 1'b0;
            hit_line_id_r <= '0;
        end else begin
            cd_in_val_r   <= issue_s;
            hit_val_r     <= cd_out_val;
            hit_line_id_r <= cd_line_id;
            if (issue_s) begin
                cd_seg_r <= pop_seg_s;
            end
        end
    end

    // Job status and per-job counters; a hit on the clearing edge counts as the first.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            seg_count_r <= '0;
            hit_count_r <= '0;
        end else begin
            busy_r <= (next_state_s == RUN) || (next_state_s == DRAIN);
            done_r <= (state_r == DRAIN) && (next_state_s == DONE);
            if (clear_cnt_s) begin
                seg_count_r <= '0;
                hit_count_r <= {{(CNT_W-1){1'b0}}, cd_out_val};
            end else begin
                if (issue_s) begin
                    seg_count_r <= sat_inc(seg_count_r);
                end
                if (cd_out_val) begin
                    hit_count_r <= sat_inc(hit_count_r);
                end
            end
        end
    end

    assign cd_in_val   = cd_in_val_r;
    assign cd_seg      = cd_seg_r;
    assign hit_val     = hit_val_r;
    assign hit_line_id = hit_line_id_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign seg_count   = seg_count_r;
    assign hit_count   = hit_count_r;

endmodule

// File: tb/tb_collision_sequencer.sv
// Directed plus randomized bench for collision_sequencer against a queue-based
// cycle reference model; honours SEQ_DEGENERATE_DROP_EN when defined.
module tb_collision_sequencer;

    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int DRN   = 16;
`ifdef SEQ_DEGENERATE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        seg_val;
    logic        seg_rdy;
    logic        seg_last;
    logic [47:0] seg_data;
    logic        cd_in_val;
    logic [47:0] cd_seg;
    logic        cd_out_val;
    logic [7:0]  cd_line_id;
    logic        hit_val;
    logic [7:0]  hit_line_id;
    logic        busy;
    logic        done;
    logic [15:0] seg_count;
    logic [15:0] hit_count;

    always #5 clk = ~clk;

    collision_sequencer #(
        .FIFO_DEPTH   (DEPTH),
        .ISSUE_GAP    (GAP),
        .DRAIN_CYCLES (DRN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_val     (seg_val),
        .seg_rdy     (seg_rdy),
        .seg_last    (seg_last),
        .seg_data    (seg_data),
        .cd_in_val   (cd_in_val),
        .cd_seg      (cd_seg),
        .cd_out_val  (cd_out_val),
        .cd_line_id  (cd_line_id),
        .hit_val     (hit_val),
        .hit_line_id (hit_line_id),
        .busy        (busy),
        .done        (done),
        .seg_count   (seg_count),
        .hit_count   (hit_count)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: segments waiting, job phase, timestamps of events.
    logic [48:0] mq [$];
    int          m_state;
    int          cyc = 0;
    int          m_last_issue;
    int          m_drain_enter;
    logic        e_cd_in_val, e_busy, e_done, e_hit_val;
    logic [47:0] e_cd_seg;
    logic [7:0]  e_hit_id;
    int          e_seg_cnt, e_hit_cnt;
    bit          rand_hits = 1'b0;
    bit          saw_full  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_edge(input logic r, input logic sv, input logic sl,
                              input logic [47:0] sd, input logic hv, input logic [7:0] hid);
        bit          accept, pop, issue, clr;
        logic [48:0] ent;
        int          nstate;
        cyc++;
        if (r) begin
            mq.delete();
            m_state = S_IDLE; m_last_issue = -1000; m_drain_enter = 0;
            e_cd_in_val = 1'b0; e_cd_seg = '0; e_hit_val = 1'b0; e_hit_id = '0;
            e_busy = 1'b0; e_done = 1'b0; e_seg_cnt = 0; e_hit_cnt = 0;
            return;
        end
        accept = sv && (mq.size() < DEPTH);
        pop    = (m_state == S_RUN) && (mq.size() > 0) && (cyc - m_last_issue >= GAP);
        ent    = pop ? mq[0] : 49'd0;
        issue  = pop && !(DROP && (ent[47:24] == ent[23:0]));
        clr    = 1'b0;
        nstate = m_state;
        e_done = 1'b0;
        case (m_state)
            S_IDLE:  if (accept || mq.size() > 0) begin nstate = S_RUN; clr = 1'b1; end
            S_RUN:   if (pop && ent[48]) begin nstate = S_DRAIN; m_drain_enter = cyc; end
            S_DRAIN: if (cyc - m_drain_enter == DRN) begin nstate = S_DONE; e_done = 1'b1; end
            default: nstate = S_IDLE;
        endcase
        e_cd_in_val = issue;
        if (issue) begin
            e_cd_seg     = ent[47:0];
            m_last_issue = cyc;
        end
        if (clr) begin
            e_seg_cnt = 0;
            e_hit_cnt = hv ? 1 : 0;
        end else begin
            if (issue) e_seg_cnt = sat(e_seg_cnt);
            if (hv)    e_hit_cnt = sat(e_hit_cnt);
        end
        e_hit_val = hv;
        e_hit_id  = hid;
        m_state   = nstate;
        e_busy    = (nstate == S_RUN) || (nstate == S_DRAIN);
        if (pop)    void'(mq.pop_front());
        if (accept) mq.push_back({sl, sd});
    endtask

    task automatic tick();
        logic r, sv, sl, hv;
        logic [47:0] sd;
        logic [7:0]  hid;
        if (rand_hits) begin
            cd_out_val = ($urandom_range(0, 3) == 0);
            cd_line_id = 8'($urandom);
        end
        r = reset; sv = seg_val; sl = seg_last; sd = seg_data; hv = cd_out_val; hid = cd_line_id;
        @(posedge clk);
        model_edge(r, sv, sl, sd, hv, hid);
        #1;
        chk("seg_rdy",     64'(seg_rdy),     64'(mq.size() < DEPTH));
        chk("cd_in_val",   64'(cd_in_val),   64'(e_cd_in_val));
        chk("cd_seg",      64'(cd_seg),      64'(e_cd_seg));
        chk("hit_val",     64'(hit_val),     64'(e_hit_val));
        chk("hit_line_id", 64'(hit_line_id), 64'(e_hit_id));
        chk("busy",        64'(busy),        64'(e_busy));
        chk("done",        64'(done),        64'(e_done));
        chk("seg_count",   64'(seg_count),   64'(e_seg_cnt));
        chk("hit_count",   64'(hit_count),   64'(e_hit_cnt));
        if (!seg_rdy) saw_full = 1'b1;
    endtask

    task automatic push_seg(input logic [47:0] d, input logic l);
        bit acc;
        seg_val = 1'b1; seg_data = d; seg_last = l;
        for (int n = 0; n < 200; n++) begin
            acc = (mq.size() < DEPTH);
            tick();
            if (acc) begin
                seg_val = 1'b0;
                return;
            end
        end
        seg_val = 1'b0;
        chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int max);
        for (int n = 0; n < max; n++) begin
            tick();
            if (e_done) return;
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_state(input int s, input int max);
        for (int n = 0; n < max; n++) begin
            if (m_state == s) return;
            tick();
        end
        chk("state_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int nq;
        reset = 1'b1; seg_val = 1'b0; seg_last = 1'b0; seg_data = '0;
        cd_out_val = 1'b0; cd_line_id = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single segment job with an engine hit during drain.
        push_seg(48'h010203040506, 1'b1);
        repeat (5) tick();
        chk("t1_busy_drain", 64'(busy), 64'd1);
        cd_out_val = 1'b1; cd_line_id = 8'h07;
        tick();
        cd_out_val = 1'b0; cd_line_id = 8'h00;
        chk("t3_hit_val", 64'(hit_val), 64'd1);
        chk("t3_hit_id", 64'(hit_line_id), 64'h07);
        chk("t3_hit_count", 64'(hit_count), 64'd1);
        wait_done(40);
        chk("t1_seg_count", 64'(seg_count), 64'd1);
        chk("t1_cd_seg", 64'(cd_seg), 64'h010203040506);
        repeat (3) tick();

        // Back-to-back burst long enough to fill the FIFO.
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++) push_seg({8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4), 8'(i + 5)}, i == 19);
        chk("t2_rdy_dropped", 64'(saw_full), 64'd1);
        wait_done(100);
        chk("t2_seg_count", 64'(seg_count), 64'd20);
        repeat (2) tick();

        // Reset in the middle of a running job with a backlog.
        for (int i = 0; i < 10; i++) push_seg({8'hA0, 8'(i), 8'h11, 8'hB0, 8'(i), 8'h22}, 1'b0);
        chk("t4_backlog", 64'(mq.size() >= 5), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rdy", 64'(seg_rdy), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        nq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cd_in_val) nq++;
        end
        chk("t4_no_issue", 64'(nq), 64'd0);

        // Zero-length segment as a complete job.
        push_seg(48'h090909090909, 1'b1);
        wait_done(40);
        chk("t5_seg_count", 64'(seg_count), DROP ? 64'd0 : 64'd1);
        repeat (2) tick();

        // Second job pushed while the first reports DONE.
        push_seg(48'h111111222222, 1'b0);
        push_seg(48'h333333444444, 1'b1);
        wait_state(S_DONE, 60);
        push_seg(48'h555555666666, 1'b0);
        push_seg(48'h777777888888, 1'b0);
        push_seg(48'h999999AAAAAA, 1'b1);
        wait_done(60);
        chk("t6_seg_count", 64'(seg_count), 64'd3);
        repeat (2) tick();

        // Randomized jobs with random hits, idle gaps and zero-length segments.
        rand_hits = 1'b1;
        for (int j = 0; j < 30; j++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int s = 0; s < len; s++) begin
                logic [23:0] a, b;
                a = 24'($urandom);
                b = ($urandom_range(0, 3) == 0) ? a : 24'($urandom);
                repeat ($urandom_range(0, 2)) tick();
                push_seg({a, b}, s == len - 1);
            end
            if (j % 3 != 2) wait_done(400);
        end
        repeat (80) tick();
        rand_hits = 1'b0;
        cd_out_val = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
